// File: rtl/asic_rstseq_pkg.sv
// Shared types and constants for the asic_rstseq reset sequencer.
// The optional ready handshake is enabled with ASIC_RSTSEQ_ACK_EN.
package asic_rstseq_pkg;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_HOLD    = 3'd1,
    ST_GAP     = 3'd2,
    ST_WAITRDY = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DEF_SYNC    = 2;
  localparam int DEF_HOLD    = 16;
  localparam int DEF_GAP     = 4;
  localparam int DEF_TIMEOUT = 255;

  // Sized so the largest phase count never wraps.
  function automatic int cnt_width(input int hold, input int gap, input int timeout);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/asic_rsync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC clock edges.
// Used for chip nreset and, with ASIC_RSTSEQ_ACK_EN, for each ready bit.
module asic_rsync
  import asic_rstseq_pkg::*;
#(
  parameter int SYNC = DEF_SYNC
) (
  input  logic clk,
  input  logic nreset,
  output logic nreset_sync
);

  logic [SYNC-1:0] sync_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], 1'b1};
    end
  end

  assign nreset_sync = sync_reg[SYNC-1];

endmodule

// File: rtl/asic_rstseq.sv
// Reset sequencer: holds all domains after nreset, then releases them in order.
// Define ASIC_RSTSEQ_ACK_EN to wait on per-domain ready between releases.
module asic_rstseq
  import asic_rstseq_pkg::*;
#(
  parameter int N       = 4,
  parameter int SYNC    = DEF_SYNC,
  parameter int HOLD    = DEF_HOLD,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         swreq,
  input  logic [N-1:0] ready,
  output logic [N-1:0] nreset_out,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int CW = cnt_width(HOLD, GAP, TIMEOUT);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic nreset_sync;

  asic_rsync #(.SYNC(SYNC)) u_nreset_sync (
    .clk         (clk),
    .nreset      (nreset),
    .nreset_sync (nreset_sync)
  );

`ifdef ASIC_RSTSEQ_ACK_EN
  logic [N-1:0] ready_sync;
  logic         unused_ready;

  // The last domain has no successor to gate, so its ready is not synchronized.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      if (gi < N - 1) begin : g_sync
        asic_rsync #(.SYNC(SYNC)) u_ready_sync (
          .clk         (clk),
          .nreset      (ready[gi]),
          .nreset_sync (ready_sync[gi])
        );
      end else begin : g_last
        assign ready_sync[gi] = 1'b0;
      end
    end
  endgenerate

  assign unused_ready = ready[N-1];
  localparam state_t REL_NEXT = ST_WAITRDY;
`else
  logic unused_ready;
  assign unused_ready = ^ready;
  localparam state_t REL_NEXT = ST_GAP;
`endif

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [N-1:0]  out_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          error_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= ST_RST;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      out_reg   <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RST: begin
          if (nreset_sync) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt_reg == CW'(HOLD - 1)) begin
            out_reg[0] <= 1'b1;
            idx_reg    <= IW'(1);
            cnt_reg    <= '0;
            if (N == 1) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= REL_NEXT;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == CW'(GAP - 1)) begin
            out_reg[idx_reg] <= 1'b1;
            cnt_reg          <= '0;
            if (idx_reg == IW'(N - 1)) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + IW'(1);
              state_reg <= REL_NEXT;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`ifdef ASIC_RSTSEQ_ACK_EN
        // idx already points past the domain just released.
        ST_WAITRDY: begin
          if (ready_sync[idx_reg - IW'(1)]) begin
            state_reg <= ST_GAP;
            cnt_reg   <= '0;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            error_reg <= 1'b1;
            state_reg <= ST_GAP;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`endif
        ST_DONE: begin
          if (swreq) begin
            out_reg   <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_HOLD;
          end
        end
        default: begin
          state_reg <= ST_RST;
        end
      endcase
    end
  end

  assign nreset_out = out_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_asic_rstseq.sv
// Scoreboard bench for asic_rstseq: expected per-edge outputs are queued
// when stimulus starts and compared one edge at a time.
module tb_asic_rstseq;

  localparam int N = 4;
`ifdef ASIC_RSTSEQ_ACK_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic         clk = 1'b0;
  logic         nreset = 1'b1;
  logic         swreq = 1'b0;
  logic [N-1:0] ready = '1;
  logic [N-1:0] nreset_out;
  logic         busy;
  logic         done;
  logic         error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         k;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       err;
    logic       sw;
  } exp_t;

  exp_t exp_q[$];

  asic_rstseq #(.N(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .swreq      (swreq),
    .ready      (ready),
    .nreset_out (nreset_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Expected state k edges after a sequence start whose first release is at edge first.
  function automatic exp_t model(int k, int first, logic sw);
    exp_t e;
    e.k   = k;
    e.out = '0;
    for (int i = 0; i < N; i++) begin
      if (k >= first + 4 * i) e.out[i] = 1'b1;
    end
    e.busy = (e.out != 4'hF);
    e.done = (e.out == 4'hF);
    e.err  = 1'b0;
    e.sw   = sw;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_nreset();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    #1 nreset = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(k, 19, 1'b1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL reset k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else begin
        $display("reset k=%0d out=%b busy=%b done=%b", e.k, nreset_out, busy, done);
      end
    end
  endtask

  task automatic test_power_on();
    exp_t e;
    logic [3:0] prev = 4'hx;
    nreset = 1'b1;
    for (int k = 1; k <= 35; k++) exp_q.push_back(model(k, 19, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL power_on k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.out !== prev) begin
        $display("power_on k=%0d out=%b busy=%b done=%b", e.k, nreset_out, busy, done);
      end
      prev = e.out;
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    release_nreset();
    for (int k = 1; k <= 25; k++) exp_q.push_back(model(k, 19, 1'b0));
    for (int k = 1; k <= 35; k++) exp_q.push_back(model(k, 19, 1'b0));
    for (int n = 0; n < 60; n++) begin
      e = exp_q.pop_front();
      if (n == 25) begin
        // Mid-sequence async reset, checked before the next clock edge.
        nreset = 1'b0;
        #1;
        checks++;
        if ({nreset_out, busy, done} !== {4'b0000, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL mid_reset_async: got out=%b busy=%b done=%b, want out=0000 busy=1 done=0",
                   nreset_out, busy, done);
        end else begin
          $display("mid_reset async out=%b busy=%b", nreset_out, busy);
        end
        tick();
        tick();
        nreset = 1'b1;
      end
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL mid_reset n=%0d k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 n, e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.k == 25 || e.k == 31) begin
        $display("mid_reset k=%0d out=%b busy=%b done=%b", e.k, nreset_out, busy, done);
      end
    end
  endtask

  task automatic test_swreq();
    exp_t e;
    logic [3:0] prev = 4'hx;
    exp_q.push_back(model(0, 16, 1'b1));
    for (int k = 1; k <= 30; k++) exp_q.push_back(model(k, 16, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL swreq k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.out !== prev) begin
        $display("swreq k=%0d out=%b busy=%b done=%b", e.k, nreset_out, busy, done);
      end
      prev = e.out;
    end
  endtask

  task automatic test_ignore_swreq();
    exp_t e;
    logic sw;
    release_nreset();
    for (int k = 1; k <= 35; k++) begin
      sw = (k == 3 || k == 10 || k == 19 || k == 22 || k == 31);
      exp_q.push_back(model(k, 19, sw));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL ignore_swreq k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.sw) begin
        $display("ignore_swreq k=%0d swreq ignored out=%b", e.k, nreset_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t m;
    release_nreset();
    for (int k = 1; k <= 31; k++) exp_q.push_back(model(k, 19, 1'b0));
    // swreq on the first DONE cycle, then again while already in HOLD.
    for (int k = 32; k <= 62; k++) begin
      m = model(k - 32, 16, (k == 32 || k == 33));
      m.k = k;
      exp_q.push_back(m);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL back_to_back k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.k == 32 || e.k == 48 || e.k == 60) begin
        $display("back_to_back k=%0d out=%b busy=%b done=%b", e.k, nreset_out, busy, done);
      end
    end
  endtask

`ifdef ASIC_RSTSEQ_ACK_EN
  task automatic test_ack();
    exp_t e;
    exp_t m;
    ready = 4'b1101;
    release_nreset();
    // Bit0 @19, ready[0] seen @20, bit1 @24, timeout @32, bit2 @36, bit3 @41.
    for (int k = 1; k <= 45; k++) begin
      m.k    = k;
      m.out  = {(k >= 41), (k >= 36), (k >= 24), (k >= 19)};
      m.busy = (m.out != 4'hF);
      m.done = (m.out == 4'hF);
      m.err  = (k >= 32);
      m.sw   = 1'b0;
      exp_q.push_back(m);
    end
    m = model(0, 16, 1'b1);
    m.k = 46;
    exp_q.push_back(m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      swreq = e.sw;
      tick();
      swreq = 1'b0;
      checks++;
      if ({nreset_out, busy, done, error} !== {e.out, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL ack k=%0d: got out=%b busy=%b done=%b err=%b, want out=%b busy=%b done=%b err=%b",
                 e.k, nreset_out, busy, done, error, e.out, e.busy, e.done, e.err);
      end else if (e.k == 24 || e.k == 32 || e.k == 36 || e.k == 46) begin
        $display("ack k=%0d out=%b err=%b", e.k, nreset_out, error);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ASIC_RSTSEQ_ACK_EN
    test_ack();
`else
    test_power_on();
    test_mid_reset();
    test_swreq();
    test_ignore_swreq();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
